// File: rtl/in_wrapper_top.sv
// Input-side wrapper for the FP adder: collects operands A and B over a four-phase
// dataReady/dataAccepted handshake, then pulses startFP. Optional macro: IN_WRAPPER_SPECIAL_EN.
module in_wrapper_top #(
  parameter int WIDTH     = 32,
  parameter bit WAIT_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dataReady,
  input  logic [WIDTH-1:0] inBus,
  input  logic             doneFP,
  output logic             dataAccepted,
  output logic             startFP,
  output logic             inBusy,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB
`ifdef IN_WRAPPER_SPECIAL_EN
  ,
  output logic [1:0]       opSpecial
`endif
);

  localparam logic [2:0] S_IDLE_A = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_ACK_A  = 3'd2;
  localparam logic [2:0] S_IDLE_B = 3'd3;
  localparam logic [2:0] S_LOAD_B = 3'd4;
  localparam logic [2:0] S_ACK_B  = 3'd5;
  localparam logic [2:0] S_START  = 3'd6;
  localparam logic [2:0] S_BUSY   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             data_accepted_q, data_accepted_d;
  logic             start_fp_q, start_fp_d;
  logic             in_busy_q, in_busy_d;

  // State, operand and output registers; outputs are decoded from the next state so
  // they stay a pure function of the current state while coming straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE_A;
      op_a_q          <= {WIDTH{1'b0}};
      op_b_q          <= {WIDTH{1'b0}};
      data_accepted_q <= 1'b0;
      start_fp_q      <= 1'b0;
      in_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      data_accepted_q <= data_accepted_d;
      start_fp_q      <= start_fp_d;
      in_busy_q       <= in_busy_d;
    end
  end

  // Next-state and operand capture; a held dataReady in ACK_x never counts as a new word.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      S_IDLE_A: begin
        if (dataReady) state_d = S_LOAD_A;
        else           state_d = S_IDLE_A;
      end
      S_LOAD_A: begin
        op_a_d  = inBus;
        state_d = S_ACK_A;
      end
      S_ACK_A: begin
        if (dataReady) state_d = S_ACK_A;
        else           state_d = S_IDLE_B;
      end
      S_IDLE_B: begin
        if (dataReady) state_d = S_LOAD_B;
        else           state_d = S_IDLE_B;
      end
      S_LOAD_B: begin
        op_b_d  = inBus;
        state_d = S_ACK_B;
      end
      S_ACK_B: begin
        if (dataReady) state_d = S_ACK_B;
        else           state_d = S_START;
      end
      S_START: begin
        if (WAIT_DONE) state_d = S_BUSY;
        else           state_d = S_IDLE_A;
      end
      S_BUSY: begin
        if (doneFP) state_d = S_IDLE_A;
        else        state_d = S_BUSY;
      end
      default: begin
        state_d = S_IDLE_A;
      end
    endcase
  end

  // Moore output decode of the state being entered.
  always_comb begin
    data_accepted_d = 1'b0;
    start_fp_d      = 1'b0;
    in_busy_d       = 1'b0;
    case (state_d)
      S_ACK_A, S_ACK_B: begin
        data_accepted_d = 1'b1;
      end
      S_START: begin
        start_fp_d = 1'b1;
        in_busy_d  = 1'b1;
      end
      S_BUSY: begin
        in_busy_d = 1'b1;
      end
      default: begin
        data_accepted_d = 1'b0;
        start_fp_d      = 1'b0;
        in_busy_d       = 1'b0;
      end
    endcase
  end

  assign dataAccepted = data_accepted_q;
  assign startFP      = start_fp_q;
  assign inBusy       = in_busy_q;
  assign opA          = op_a_q;
  assign opB          = op_b_q;

`ifdef IN_WRAPPER_SPECIAL_EN
  // Exponent all-ones flags Inf/NaN operands; assumes single-precision layout.
  assign opSpecial = {&op_b_q[30:23], &op_a_q[30:23]};
`endif

endmodule

// File: tb/tb_in_wrapper_top.sv
// Randomized bench for in_wrapper_top: a handshaking source drives operand pairs and a
// transaction-level model checks captured operands, handshake timing and start/busy behaviour.
module tb_in_wrapper_top;

  logic        clk;
  logic        rst;
  logic        dataReady;
  logic [31:0] inBus;
  logic        doneFP;
  logic        dataAccepted;
  logic        startFP;
  logic        inBusy;
  logic [31:0] opA;
  logic [31:0] opB;
`ifdef IN_WRAPPER_SPECIAL_EN
  logic [1:0]  opSpecial;
`endif

  int errs;
  int checks;
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  in_wrapper_top #(.WIDTH(32), .WAIT_DONE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .dataReady    (dataReady),
    .inBus        (inBus),
    .doneFP       (doneFP),
    .dataAccepted (dataAccepted),
    .startFP      (startFP),
    .inBusy       (inBusy),
    .opA          (opA),
    .opB          (opB)
`ifdef IN_WRAPPER_SPECIAL_EN
    ,
    .opSpecial    (opSpecial)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ops(input string tag);
    logic [1:0] sp;
    check_eq({tag, "_opA"}, opA, exp_a);
    check_eq({tag, "_opB"}, opB, exp_b);
    sp = {&exp_b[30:23], &exp_a[30:23]};
`ifdef IN_WRAPPER_SPECIAL_EN
    check_eq({tag, "_special"}, {30'd0, opSpecial}, {30'd0, sp});
`endif
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_acc"}, {31'd0, dataAccepted}, 32'd0);
    check_eq({tag, "_start"}, {31'd0, startFP}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, inBusy}, 32'd0);
  endtask

  // One four-phase word transfer; short_pulse drops dataReady while the word is loading.
  task automatic send_word(input logic [31:0] w, input bit is_b, input int hold, input bit short_pulse);
    int n;
    inBus     = w;
    dataReady = 1'b1;
    n = 0;
    if (short_pulse) begin
      step();
      check_eq("acc_in_load", {31'd0, dataAccepted}, 32'd0);
      dataReady = 1'b0;
      step();
      n = 2;
    end else begin
      do begin
        step();
        n++;
      end while (!dataAccepted && n < 8);
    end
    check_eq("acc_latency", n, 32'd2);
    check_eq("acc_rise", {31'd0, dataAccepted}, 32'd1);
    if (is_b) exp_b = w;
    else      exp_a = w;
    check_ops("capture");
    inBus = $urandom();
    if (!short_pulse) begin
      for (int i = 0; i < hold; i++) begin
        step();
        check_eq("acc_hold", {31'd0, dataAccepted}, 32'd1);
        check_eq("start_in_ack", {31'd0, startFP}, 32'd0);
        check_ops("hold");
      end
      dataReady = 1'b0;
    end
    step();
    check_eq("acc_fall", {31'd0, dataAccepted}, 32'd0);
  endtask

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int ha, input int hb,
                          input bit sa, input bit sb, input int busy, input bit early);
    int gap;
    send_word(a, 1'b0, ha, sa);
    gap = $urandom_range(0, 3);
    for (int i = 0; i < gap; i++) begin
      doneFP = 1'($urandom_range(0, 1));
      step();
      check_idle("idle_b");
      check_ops("idle_b");
    end
    doneFP = 1'b0;
    send_word(b, 1'b1, hb, sb);
    check_eq("start_pulse", {31'd0, startFP}, 32'd1);
    check_eq("busy_start", {31'd0, inBusy}, 32'd1);
    check_ops("start");
    if (early) doneFP = 1'b1;
    step();
    check_eq("start_once", {31'd0, startFP}, 32'd0);
    check_eq("busy_enter", {31'd0, inBusy}, 32'd1);
    if (early) begin
      step();
      check_eq("early_done", {31'd0, inBusy}, 32'd0);
      doneFP = 1'b0;
    end else begin
      for (int i = 0; i < busy; i++) begin
        dataReady = 1'($urandom_range(0, 1));
        inBus     = $urandom();
        step();
        check_eq("busy_hold", {31'd0, inBusy}, 32'd1);
        check_eq("busy_acc", {31'd0, dataAccepted}, 32'd0);
        check_eq("busy_start", {31'd0, startFP}, 32'd0);
        check_ops("busy");
      end
      doneFP    = 1'b1;
      dataReady = 1'b0;
      step();
      check_eq("done_exit", {31'd0, inBusy}, 32'd0);
      check_ops("done");
      doneFP = 1'b0;
    end
  endtask

  // Asynchronous reset applied between clock edges, then released away from an edge.
  task automatic reset_now(input string tag);
    #1 rst = 1'b1;
    #1;
    exp_a = 32'd0;
    exp_b = 32'd0;
    check_idle({tag, "_async"});
    check_ops({tag, "_async"});
    dataReady = 1'b0;
    doneFP    = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_idle({tag, "_post"});
    check_ops({tag, "_post"});
  endtask

  task automatic reset_mid(input int pre);
    dataReady = 1'b1;
    inBus     = $urandom();
    for (int i = 0; i < pre; i++) step();
    reset_now("rst_mid");
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) == 0) w[30:23] = 8'hFF;
    return w;
  endfunction

  initial begin
    errs      = 0;
    checks    = 0;
    exp_a     = 32'd0;
    exp_b     = 32'd0;
    rst       = 1'b1;
    dataReady = 1'b0;
    inBus     = 32'd0;
    doneFP    = 1'b0;
    repeat (3) step();
    check_idle("reset");
    check_ops("reset");
    rst = 1'b0;
    step();
    check_idle("post_reset");

    run_pair(32'h3F800000, 32'h40000000, 0, 0, 1'b0, 1'b0, 3, 1'b0);
    run_pair(rand_word(), rand_word(), 10, 0, 1'b0, 1'b0, 20, 1'b0);
    run_pair(rand_word(), rand_word(), 0, 10, 1'b0, 1'b0, 0, 1'b0);
    run_pair(rand_word(), rand_word(), 2, 1, 1'b0, 1'b0, 0, 1'b1);
    run_pair(rand_word(), rand_word(), 0, 0, 1'b1, 1'b1, 2, 1'b0);

    // Reset while ACK_B is holding dataAccepted high.
    send_word(32'h12345678, 1'b0, 0, 1'b0);
    inBus     = 32'h9ABCDEF0;
    dataReady = 1'b1;
    step();
    step();
    check_eq("ackb_reached", {31'd0, dataAccepted}, 32'd1);
    reset_now("rst_ackb");
    run_pair(32'hC0400000, 32'h3F000000, 1, 1, 1'b0, 1'b0, 2, 1'b0);

    reset_mid(4);
    run_pair(32'h7F800000, 32'h7FC00000, 0, 0, 1'b0, 1'b0, 1, 1'b0);
    run_pair(32'h3F800000, 32'h40000000, 0, 0, 1'b0, 1'b0, 1, 1'b0);

    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 9) == 0) reset_mid($urandom_range(0, 7));
      run_pair(rand_word(), rand_word(), $urandom_range(0, 4), $urandom_range(0, 4),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
